// File: rtl/prog_ctr_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, PC width and the
// branch-take equation used by the branch resolver.
package prog_ctr_fetch_pkg;

  localparam int PC_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic branch_take(
    input logic branch_ez,
    input logic branch_nz,
    input logic branch_always,
    input logic zero_flag
  );
    return branch_always | (branch_ez & zero_flag) | (branch_nz & ~zero_flag);
  endfunction

endpackage

// File: rtl/prog_ctr_fetch_branch_resolve.sv
// Combinational branch resolution: decides whether the decoder's strobes take
// a branch and chooses between the zero-extended target and the sequential PC.
module prog_ctr_fetch_branch_resolve
  import prog_ctr_fetch_pkg::*;
#(
  parameter int T = PC_W,
  parameter int W = 8
) (
  input  logic         branch_ez,
  input  logic         branch_nz,
  input  logic         branch_always,
  input  logic         zero_flag,
  input  logic [W-1:0] target_reg,
  input  logic [T-1:0] pc_p1,
  output logic         take,
  output logic [T-1:0] next_pc,
  output logic         wrap
);

  logic [T-1:0] target_ext;

  // Target zero-extension, branch select and sequential-wrap detection
  always_comb begin
    target_ext = {T{1'b0}};
    target_ext[W-1:0] = target_reg;
    take = branch_take(branch_ez, branch_nz, branch_always, zero_flag);
    if (take) begin
      next_pc = target_ext;
      wrap    = 1'b0;
    end else begin
      next_pc = pc_p1;
      // pc_p1 only reads zero when pc was all-ones
      wrap    = (pc_p1 == {T{1'b0}});
    end
  end

endmodule

// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch sequencer: IDLE/RUN/HALT handshake, PC register,
// saturating retired-instruction counter and sticky PC-wrap flag.
module prog_ctr_fetch
  import prog_ctr_fetch_pkg::*;
#(
  parameter int             T        = PC_W,
  parameter int             W        = 8,
  parameter logic [T-1:0]   START_PC = {T{1'b0}},
  parameter int             CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_ez,
  input  logic             branch_nz,
  input  logic             branch_always,
  input  logic             zero_flag,
  input  logic [W-1:0]     target_reg,
  input  logic             done_in,
  output logic [T-1:0]     pc,
  output logic [T-1:0]     pc_p1,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] retired,
  output logic             pc_wrap_err
);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [T-1:0]     pc_next;
  logic [CNT_W-1:0] retired_next;
  logic             wrap_err_next;
  logic             take;
  logic [T-1:0]     resolved_pc;
  logic             wrap;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end else begin
      return val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign pc_p1 = pc + {{(T-1){1'b0}}, 1'b1};

  prog_ctr_fetch_branch_resolve #(
    .T (T),
    .W (W)
  ) u_branch_resolve (
    .branch_ez     (branch_ez),
    .branch_nz     (branch_nz),
    .branch_always (branch_always),
    .zero_flag     (zero_flag),
    .target_reg    (target_reg),
    .pc_p1         (pc_p1),
    .take          (take),
    .next_pc       (resolved_pc),
    .wrap          (wrap)
  );

  // Next-state, next-PC, counter and error-flag selection
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    retired_next  = retired;
    wrap_err_next = pc_wrap_err;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_next    = RUN;
          pc_next       = START_PC;
          retired_next  = {CNT_W{1'b0}};
          wrap_err_next = 1'b0;
        end else begin
          state_next = state;
        end
      end
      RUN: begin
        if (stall) begin
          state_next = RUN;
        end else if (done_in) begin
          // pc stays on the DNE address, which still retires
          state_next   = HALT;
          retired_next = sat_inc(retired);
        end else begin
          pc_next      = resolved_pc;
          retired_next = sat_inc(retired);
          if (wrap) begin
            wrap_err_next = 1'b1;
          end else begin
            wrap_err_next = pc_wrap_err;
          end
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = START_PC;
      end
    endcase
  end

  // State, PC, counter, flag and status-output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_PC;
      retired     <= {CNT_W{1'b0}};
      pc_wrap_err <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      retired     <= retired_next;
      pc_wrap_err <= wrap_err_next;
      running     <= (state_next == RUN);
      done        <= (state_next == HALT);
    end
  end

endmodule
